// File: rtl/sraml_pkg.sv
// Shared types for the sram-like responder: size encodings, the pending-request
// record and the byte-strobe decode.
package sraml_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_RSVD = 2'd3
    } size_e;

    // Wide enough for a countdown of LATENCY-1 with LATENCY up to 15.
    localparam int CNT_W = 4;

    typedef struct packed {
        logic             wr;
        size_e            size;
        logic [31:0]      addr;
        logic [31:0]      wdata;
        logic [CNT_W-1:0] cnt;
    } pend_t;

    function automatic logic [3:0] strobe(input size_e size, input logic [1:0] lo);
        logic [3:0] s;
        unique case (size)
            SZ_BYTE: s = 4'b0001 << lo;
            SZ_HALF: s = lo[1] ? 4'b1100 : 4'b0011;
            default: s = 4'b1111;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/sraml_req_queue.sv
// In-order pending-request FIFO; every entry counts down independently and the
// head pops once its countdown reaches zero.
module sraml_req_queue
    import sraml_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter int LATENCY = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  pend_t                        push_entry,
    input  logic                         pop,
    output logic                         head_valid,
    output logic                         head_done,
    output pend_t                        head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = $clog2(DEPTH + 1);

    pend_t             entries [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: entry storage has no reset; validity comes solely from count/pointers,
    // so clearing the payload would only add reset fan-out.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (entries[i].cnt != '0) entries[i].cnt <= entries[i].cnt - 1'b1;
        end
        if (push) begin
            entries[wr_ptr]     <= push_entry;
            entries[wr_ptr].cnt <= CNT_W'(LATENCY - 1);
        end
    end

    assign head       = entries[rd_ptr];
    assign head_valid = (count != '0);
    assign head_done  = head_valid && (head.cnt == '0);

endmodule

// File: rtl/sraml_ram_slave.sv
// Sram-like bus responder backed by a word array: pipelined, in-order completion
// after a fixed latency, byte/half/word strobed writes.
module sraml_ram_slave
    import sraml_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2,
    parameter int DEPTH   = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req,
    input  logic                         wr,
    input  logic [1:0]                   size,
    input  logic [31:0]                  addr,
    input  logic [31:0]                  wdata,
    input  logic                         accept_en,
    output logic                         addr_ok,
    output logic                         data_ok,
    output logic [31:0]                  rdata,
    output logic [$clog2(DEPTH+1)-1:0]   outstanding
);

    localparam int OUT_W = $clog2(DEPTH + 1);

    logic [31:0]       mem [2**ADDR_W];
    pend_t             push_entry;
    pend_t             head;
    logic              head_valid;
    logic              head_done;
    logic              complete;
    logic              push;
    logic [OUT_W-1:0]  count;
    logic [ADDR_W-1:0] head_idx;
    logic [3:0]        head_strb;
    logic              unused_head;

    // A completing head frees its slot on the same edge, so a full queue can still accept.
    assign complete = head_valid && head_done && !rst;
    assign addr_ok  = req && accept_en && !rst && ((count < OUT_W'(DEPTH)) || head_done);
    assign push     = req && addr_ok;

    assign push_entry = '{wr: wr, size: size_e'(size), addr: addr, wdata: wdata, cnt: '0};

    sraml_req_queue #(
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (complete),
        .head_valid (head_valid),
        .head_done  (head_done),
        .head       (head),
        .count      (count)
    );

    // Upper address bits alias onto the array.
    assign head_idx    = head.addr[ADDR_W+1:2];
    assign head_strb   = strobe(head.size, head.addr[1:0]);
    assign unused_head = ^{head.addr[31:ADDR_W+2], head.cnt};

    always_ff @(posedge clk) begin
        if (complete && head.wr) begin
            for (int b = 0; b < 4; b++) begin
                if (head_strb[b]) mem[head_idx][8*b +: 8] <= head.wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_ok <= 1'b0;
            rdata   <= '0;
        end else begin
            data_ok <= complete;
            rdata   <= (complete && !head.wr) ? mem[head_idx] : '0;
        end
    end

    assign outstanding = count;

endmodule

// File: tb/tb_sraml_ram_slave.sv
// Bench for sraml_ram_slave: timestamp-based transaction model for the 2/2 instance,
// directed cadence checks for a 3/1 instance.
module tb_sraml_ram_slave;

    localparam int LAT = 2;
    localparam int DEP = 2;

    logic        clk = 1'b0;
    logic        rst, req, wr, accept_en;
    logic [1:0]  size;
    logic [31:0] addr, wdata, rdata;
    logic        addr_ok, data_ok;
    logic [1:0]  outstanding;

    logic        rst_b, req_b, wr_b, accept_en_b;
    logic [1:0]  size_b;
    logic [31:0] addr_b, wdata_b, rdata_b;
    logic        addr_ok_b, data_ok_b;
    logic [0:0]  outstanding_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sraml_ram_slave #(.ADDR_W(10), .LATENCY(LAT), .DEPTH(DEP)) dut (
        .clk(clk), .rst(rst), .req(req), .wr(wr), .size(size), .addr(addr),
        .wdata(wdata), .accept_en(accept_en), .addr_ok(addr_ok), .data_ok(data_ok),
        .rdata(rdata), .outstanding(outstanding)
    );

    sraml_ram_slave #(.ADDR_W(10), .LATENCY(3), .DEPTH(1)) dut_b (
        .clk(clk), .rst(rst_b), .req(req_b), .wr(wr_b), .size(size_b), .addr(addr_b),
        .wdata(wdata_b), .accept_en(accept_en_b), .addr_ok(addr_ok_b), .data_ok(data_ok_b),
        .rdata(rdata_b), .outstanding(outstanding_b)
    );

    typedef struct {
        int unsigned due;
        bit          wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } op_t;

    op_t         mq[$];
    logic [31:0] mm [1024];
    int unsigned cyc = 0;
    bit          m_dok = 1'b0;
    logic [31:0] m_rdata = '0;
    bit          last_acc = 1'b0;
    logic [31:0] obs_last = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [1:0] sz, input logic [1:0] lo);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            bit hit;
            case (sz)
                2'd0:    hit = (b == int'(lo));
                2'd1:    hit = ((b / 2) == int'(lo[1]));
                default: hit = 1'b1;
            endcase
            if (hit) r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

    // One clock of the 2/2 instance: compare outputs at negedge, then advance the model.
    task automatic tick();
        bit  exp_ok;
        op_t op;
        @(negedge clk);
        exp_ok = req && accept_en && !rst && (mq.size() < DEP);
        if (req && accept_en && !rst && mq.size() > 0) begin
            if (mq[0].due == cyc) exp_ok = 1'b1;
        end
        check("addr_ok", 32'(addr_ok), 32'(exp_ok));
        check("data_ok", 32'(data_ok), 32'(m_dok));
        if (m_dok && !$isunknown(m_rdata)) check("rdata", rdata, m_rdata);
        check("outstanding", 32'(outstanding), 32'(mq.size()));
        if (data_ok) obs_last = rdata;
        last_acc = exp_ok;
        @(posedge clk);
        m_dok   = 1'b0;
        m_rdata = '0;
        if (rst) begin
            mq.delete();
        end else begin
            if (mq.size() > 0 && mq[0].due == cyc) begin
                op    = mq.pop_front();
                m_dok = 1'b1;
                if (op.wr) mm[op.addr[11:2]] = merge(mm[op.addr[11:2]], op.wdata, op.size, op.addr[1:0]);
                else       m_rdata = mm[op.addr[11:2]];
            end
            if (exp_ok) mq.push_back('{cyc + LAT, wr, size, addr, wdata});
        end
        cyc++;
        #1;
    endtask

    task automatic issue(input bit w, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        int n;
        req = 1'b1; wr = w; size = sz; addr = a; wdata = d;
        n = 0;
        do begin
            tick();
            n++;
        end while (!last_acc && n < 20);
        check("issue_accepted", 32'(last_acc), 32'd1);
        req = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((mq.size() != 0 || m_dok) && n < 50) begin
            tick();
            n++;
        end
        check("drain_empty", 32'(mq.size()), 32'd0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mm[i] = 'x;
        rst = 1'b1; req = 1'b0; wr = 1'b0; size = 2'd2; addr = '0; wdata = '0; accept_en = 1'b1;
        rst_b = 1'b1; req_b = 1'b0; wr_b = 1'b0; size_b = 2'd2; addr_b = '0; wdata_b = '0; accept_en_b = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        req = 1'b1;  // request during reset must be refused
        tick();
        req = 1'b0;
        tick();
        check("reset_rdata", rdata, 32'h0);
        rst = 1'b0;

        // Write then read back-to-back.
        issue(1'b1, 2'd2, 32'h10, 32'hDEADBEEF);
        issue(1'b0, 2'd2, 32'h10, 32'h0);
        drain();
        check("t1_readback", obs_last, 32'hDEADBEEF);

        // Byte and half strobes.
        issue(1'b1, 2'd2, 32'h14, 32'h11223344);
        issue(1'b1, 2'd0, 32'h17, 32'hAAAAAAAA);
        issue(1'b0, 2'd2, 32'h14, 32'h0);
        drain();
        check("t2_byte", obs_last, 32'hAA223344);
        issue(1'b1, 2'd1, 32'h16, 32'hBEEFBEEF);
        issue(1'b0, 2'd0, 32'h14, 32'h0);
        drain();
        check("t2_half", obs_last, 32'hBEEF3344);

        // Preload then four back-to-back reads.
        for (int i = 0; i < 4; i++) issue(1'b1, 2'd2, 32'(4 * i), 32'(i + 1));
        drain();
        for (int i = 0; i < 4; i++) issue(1'b0, 2'd2, 32'(4 * i), 32'h0);
        drain();
        check("t3_last", obs_last, 32'd4);

        // Reset discards a pending read; committed write survives.
        issue(1'b1, 2'd2, 32'h20, 32'h55);
        drain();
        issue(1'b0, 2'd2, 32'h20, 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (4) tick();
        check("t5_outstanding", 32'(outstanding), 32'd0);
        issue(1'b0, 2'd2, 32'h20, 32'h0);
        drain();
        check("t5_persist", obs_last, 32'h55);

        // Aliasing of upper address bits.
        issue(1'b1, 2'd2, 32'h1000_0004, 32'h12345678);
        issue(1'b0, 2'd2, 32'h0000_0004, 32'h0);
        drain();
        check("t6_alias", obs_last, 32'h12345678);

        // Randomized traffic over words 0..15 with aliased upper bits and backpressure.
        for (int i = 0; i < 16; i++) issue(1'b1, 2'd2, 32'(4 * i), $urandom);
        drain();
        for (int i = 0; i < 400; i++) begin
            if (!req || last_acc) begin
                if ($urandom_range(0, 3) != 0) begin
                    req   = 1'b1;
                    wr    = 1'($urandom_range(0, 1));
                    size  = 2'($urandom_range(0, 3));
                    addr  = $urandom & 32'hFFFF_F03F;
                    wdata = $urandom;
                end else begin
                    req = 1'b0;
                end
            end
            accept_en = ($urandom_range(0, 4) != 0);
            tick();
        end
        req = 1'b0;
        accept_en = 1'b1;
        drain();

        // LATENCY=3, DEPTH=1 with req held: one acceptance per 3 cycles, then throttled off.
        @(posedge clk);
        #1;
        rst_b = 1'b0;
        req_b = 1'b1;
        for (int k = 0; k < 17; k++) begin
            accept_en_b = (k < 12);
            @(negedge clk);
            check("b_addr_ok", 32'(addr_ok_b), 32'((k < 12) && (k % 3 == 0)));
            check("b_data_ok", 32'(data_ok_b), 32'((k >= 4) && (k <= 13) && (k % 3 == 1)));
            check("b_outstanding", 32'(outstanding_b), 32'((k >= 1) && (k <= 12)));
            @(posedge clk);
            #1;
        end
        req_b = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
